instr_memory: RTL

Instruction memory serving the core's fetch port, with a built-in byte-stream program loader. The fetch side answers word reads with one cycle of registered latency. The load side accepts a little-endian byte stream over a valid/ready handshake, assembles the bytes into 32-bit words and writes them sequentially from word 0. While a load is in progress, the block holds the core in reset and returns NOPs, so the core boots cleanly into the new image once the load finishes.

---
 rtl/instr_memory_if.sv | 24 ++
 rtl/instr_memory.sv | 103 ++++++++++
 2 files changed

// File: rtl/instr_memory_if.sv
// rtl/instr_memory_if.sv - fetch port and byte-stream program loader signals for instr_memory
interface instr_memory_if;
    logic [31:0] instr_rd_addr;
    logic [31:0] instr_rd_data;
    logic        load_start;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic        core_hold;

    modport master (
        output instr_rd_addr, load_start, load_valid, load_byte, load_last,
        input  instr_rd_data, load_ready, load_busy, load_done, load_err, core_hold
    );

    modport slave (
        input  instr_rd_addr, load_start, load_valid, load_byte, load_last,
        output instr_rd_data, load_ready, load_busy, load_done, load_err, core_hold
    );
endinterface

// File: rtl/instr_memory.sv
// rtl/instr_memory.sv - instruction memory with 1-cycle fetch and little-endian byte-stream loader
module instr_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_memory_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lane;
    logic [AW:0] word_addr;
    logic [31:0] asm_word;
    logic [31:0] merged;
    logic [31:0] rd_data;
    logic        done_q;
    logic        err_q;
    logic        accept;
    logic        ovf;
    logic        wr_en;
    logic        rd_in_range;
    logic        unused_addr_lsbs;
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.load_ready = 1'b0;
        bus.load_busy  = 1'b0;
        bus.core_hold  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.load_ready = 1'b1;
                bus.load_busy  = 1'b1;
                bus.core_hold  = 1'b1;
                if (bus.load_valid && bus.load_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // word_addr saturates at DEPTH_WORDS, so its top bit doubles as the overflow marker
    assign accept = bus.load_valid && (state == LOAD);
    assign ovf    = word_addr[AW];
    assign merged = asm_word | ({24'd0, bus.load_byte} << {lane, 3'b000});
    assign wr_en  = accept && !ovf && ((lane == 2'd3) || bus.load_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane      <= 2'd0;
            word_addr <= '0;
            asm_word  <= 32'd0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= accept && bus.load_last;
            if (state == IDLE && bus.load_start) begin
                lane      <= 2'd0;
                word_addr <= '0;
                asm_word  <= 32'd0;
                err_q     <= 1'b0;
            end else if (accept) begin
                lane <= lane + 2'd1;
                if (ovf) err_q <= 1'b1;
                if (lane == 2'd3 || bus.load_last) begin
                    asm_word <= 32'd0;
                    if (!ovf && lane == 2'd3) word_addr <= word_addr + 1'b1;
                end else begin
                    asm_word <= merged;
                end
            end
        end
    end

    // Contents survive reset; only the write is gated so a reset cycle cannot commit a byte
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[word_addr[AW-1:0]] <= merged;
    end

    assign rd_in_range      = (bus.instr_rd_addr[31:AW+2] == '0);
    assign unused_addr_lsbs = ^bus.instr_rd_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n)                             rd_data <= NOP_INSTR;
        else if (state == LOAD || !rd_in_range) rd_data <= NOP_INSTR;
        else                                    rd_data <= mem[bus.instr_rd_addr[AW+1:2]];
    end

    assign bus.instr_rd_data = rd_data;
    assign bus.load_done     = done_q;
    assign bus.load_err      = err_q;
endmodule
